// File: rtl/piece_drop_ctrl.sv
// Falling-piece controller: moves a straight piece under keys and gravity,
// locks it into the grid, clears full rows bottom-up and respawns.
module piece_drop_ctrl #(
  parameter int COLS        = 10,
  parameter int ROWS        = 20,
  parameter int PIECE_LEN   = 4,
  parameter int DROP_PERIOD = 30,
  parameter int SPAWN_X     = 3,
  parameter int XW          = $clog2(COLS),
  parameter int YW          = $clog2(ROWS)
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [7:0]               keycode,
  output logic [XW-1:0]            piece_x,
  output logic [YW-1:0]            piece_y,
  output logic                     piece_vert,
  output logic [1:0]               piece_color,
  output logic [ROWS*COLS-1:0]     grid_occ,
  output logic [2*ROWS*COLS-1:0]   grid_color,
  output logic [15:0]              lines_cleared,
  output logic                     busy,
  output logic                     game_over
);

  localparam int NCELLS = ROWS * COLS;
  localparam int CW     = $clog2(NCELLS);
  localparam int GW     = $clog2(DROP_PERIOD);

  localparam logic [7:0] K_LEFT  = 8'h04;
  localparam logic [7:0] K_RIGHT = 8'h07;
  localparam logic [7:0] K_ROT   = 8'h1A;
  localparam logic [7:0] K_DOWN  = 8'h16;
  localparam logic [7:0] K_DROP  = 8'h2C;

  typedef enum logic [2:0] {
    S_FALL, S_HARD, S_LOCK, S_CLEAR, S_SPAWN, S_OVER
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        prev_key;
  logic [GW-1:0]     grav_cnt;
  logic [YW-1:0]     row_ptr;

  // Footprint test in one bit wider arithmetic so x-1 at 0 and the far end
  // of the piece both land out of range instead of wrapping.
  function automatic logic fits(input logic [XW:0] fx, input logic [YW:0] fy,
                                input logic fv, input logic [NCELLS-1:0] occ);
    int cx, cy;
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < PIECE_LEN; k++) begin
      cx = int'(fx) + (fv ? 0 : k);
      cy = int'(fy) + (fv ? k : 0);
      if (cx >= COLS || cy >= ROWS) ok = 1'b0;
      else if (occ[CW'(cy * COLS + cx)]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [NCELLS-1:0] cell_mask(input logic [XW-1:0] fx,
                                                  input logic [YW-1:0] fy,
                                                  input logic fv);
    logic [NCELLS-1:0] m;
    int cx, cy;
    m = '0;
    for (int k = 0; k < PIECE_LEN; k++) begin
      cx = int'(fx) + (fv ? 0 : k);
      cy = int'(fy) + (fv ? k : 0);
      if (cx < COLS && cy < ROWS) m[CW'(cy * COLS + cx)] = 1'b1;
    end
    return m;
  endfunction

  logic [XW:0] x_ext, x_left, x_right;
  logic [YW:0] y_ext, y_down;
  logic        fit_left, fit_right, fit_rot, fit_down, fit_spawn;
  logic        key_event, act_key, grav_due;

  assign x_ext   = {1'b0, piece_x};
  assign x_left  = x_ext - (XW+1)'(1);
  assign x_right = x_ext + (XW+1)'(1);
  assign y_ext   = {1'b0, piece_y};
  assign y_down  = y_ext + (YW+1)'(1);

  assign fit_left  = fits(x_left,  y_ext,  piece_vert,  grid_occ);
  assign fit_right = fits(x_right, y_ext,  piece_vert,  grid_occ);
  assign fit_rot   = fits(x_ext,   y_ext,  ~piece_vert, grid_occ);
  assign fit_down  = fits(x_ext,   y_down, piece_vert,  grid_occ);
  assign fit_spawn = fits((XW+1)'(SPAWN_X), '0, 1'b0, grid_occ);

  assign key_event = (keycode != 8'h00) && (keycode != prev_key);
  assign act_key   = key_event && (keycode inside {K_LEFT, K_RIGHT, K_ROT, K_DOWN, K_DROP});
  assign grav_due  = (grav_cnt == GW'(DROP_PERIOD - 1));

  logic [NCELLS-1:0]   piece_mask;
  logic [2*NCELLS-1:0] lock_color;
  logic [CW-1:0]       row_base;
  logic                row_full;
  logic [NCELLS-1:0]   shift_occ;
  logic [2*NCELLS-1:0] shift_color;

  assign piece_mask = cell_mask(piece_x, piece_y, piece_vert);
  assign row_base   = CW'(row_ptr * COLS);
  assign row_full   = &grid_occ[row_base +: COLS];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lock_color = grid_color;
    for (int i = 0; i < NCELLS; i++)
      if (piece_mask[i]) lock_color[i*2 +: 2] = piece_color;
  end

  // Rows 1..row_ptr take the row above; row 0 becomes empty.
  always_comb begin
    shift_occ   = grid_occ;
    shift_color = grid_color;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        shift_occ[0 +: COLS]     = '0;
        shift_color[0 +: 2*COLS] = '0;
      end else if (r <= int'(row_ptr)) begin
        shift_occ[r*COLS +: COLS]       = grid_occ[(r-1)*COLS +: COLS];
        shift_color[r*2*COLS +: 2*COLS] = grid_color[(r-1)*2*COLS +: 2*COLS];
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) state <= S_FALL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FALL: begin
        if (act_key) begin
          if (keycode == K_DOWN && !fit_down) state_nxt = S_LOCK;
          else if (keycode == K_DROP)         state_nxt = S_HARD;
        end else if (grav_due && !fit_down) begin
          state_nxt = S_LOCK;
        end
      end
      S_HARD:  if (!fit_down) state_nxt = S_LOCK;
      S_LOCK:  state_nxt = S_CLEAR;
      S_CLEAR: if (!row_full && row_ptr == '0) state_nxt = S_SPAWN;
      S_SPAWN: state_nxt = fit_spawn ? S_FALL : S_OVER;
      S_OVER:  state_nxt = S_OVER;
      default: state_nxt = S_FALL;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    game_over = 1'b0;
    case (state)
      S_HARD, S_LOCK, S_CLEAR, S_SPAWN: busy = 1'b1;
      S_OVER:  game_over = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      // NOTE: the grid is architectural state, so it is cleared on reset
      // rather than left as an unreset memory.
      grid_occ      <= '0;
      grid_color    <= '0;
      lines_cleared <= '0;
      piece_x       <= XW'(SPAWN_X);
      piece_y       <= '0;
      piece_vert    <= 1'b0;
      piece_color   <= 2'd1;
      grav_cnt      <= '0;
      prev_key      <= '0;
      row_ptr       <= '0;
    end else begin
      prev_key <= keycode;
      case (state)
        S_FALL: begin
          if (act_key) begin
            case (keycode)
              K_LEFT:  if (fit_left)  piece_x <= x_left[XW-1:0];
              K_RIGHT: if (fit_right) piece_x <= x_right[XW-1:0];
              K_ROT:   if (fit_rot)   piece_vert <= ~piece_vert;
              K_DOWN:  if (fit_down)  piece_y <= y_down[YW-1:0];
              default: ;
            endcase
            // A key beats gravity; a due drop is deferred to the next frame.
            if (keycode == K_DOWN) grav_cnt <= '0;
            else if (!grav_due)    grav_cnt <= grav_cnt + GW'(1);
          end else if (grav_due) begin
            grav_cnt <= '0;
            if (fit_down) piece_y <= y_down[YW-1:0];
          end else begin
            grav_cnt <= grav_cnt + GW'(1);
          end
        end
        S_HARD: if (fit_down) piece_y <= y_down[YW-1:0];
        S_LOCK: begin
          grid_occ   <= grid_occ | piece_mask;
          grid_color <= lock_color;
          row_ptr    <= YW'(ROWS - 1);
        end
        S_CLEAR: begin
          if (row_full) begin
            grid_occ   <= shift_occ;
            grid_color <= shift_color;
            if (lines_cleared != 16'hFFFF) lines_cleared <= lines_cleared + 16'd1;
          end else if (row_ptr != '0) begin
            row_ptr <= row_ptr - YW'(1);
          end
        end
        S_SPAWN: begin
          piece_x     <= XW'(SPAWN_X);
          piece_y     <= '0;
          piece_vert  <= 1'b0;
          piece_color <= (piece_color == 2'd3) ? 2'd1 : piece_color + 2'd1;
          grav_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Bench for piece_drop_ctrl: array-based playfield model checked every frame,
// plus hand-computed expectations along the directed scenario.
module tb_piece_drop_ctrl;

  localparam int COLS = 10, ROWS = 20, PIECE_LEN = 4, DROP_PERIOD = 30, SPAWN_X = 3;
  localparam int XW = $clog2(COLS), YW = $clog2(ROWS);

  localparam logic [7:0] K_LEFT = 8'h04, K_RIGHT = 8'h07, K_ROT = 8'h1A,
                         K_DOWN = 8'h16, K_DROP = 8'h2C;

  localparam int MF = 0, MH = 1, ML = 2, MC = 3, MS = 4, MO = 5;

  logic                   frame_clk, Reset;
  logic [7:0]             keycode;
  logic [XW-1:0]          piece_x;
  logic [YW-1:0]          piece_y;
  logic                   piece_vert;
  logic [1:0]             piece_color;
  logic [ROWS*COLS-1:0]   grid_occ;
  logic [2*ROWS*COLS-1:0] grid_color;
  logic [15:0]            lines_cleared;
  logic                   busy, game_over;

  piece_drop_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .PIECE_LEN(PIECE_LEN),
    .DROP_PERIOD(DROP_PERIOD), .SPAWN_X(SPAWN_X)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .piece_x(piece_x), .piece_y(piece_y), .piece_vert(piece_vert),
    .piece_color(piece_color), .grid_occ(grid_occ), .grid_color(grid_color),
    .lines_cleared(lines_cleared), .busy(busy), .game_over(game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Playfield model
  int m_occ[ROWS][COLS], m_col[ROWS][COLS];
  int p_occ[ROWS][COLS], p_col[ROWS][COLS];
  int m_x, m_y, m_v, m_pc, m_grav, m_prev, m_mode, m_lines, m_left, m_k;
  bit m_valid = 0;

  function automatic bit m_fits(input int x, input int y, input int v);
    int cx, cy;
    for (int k = 0; k < PIECE_LEN; k++) begin
      cx = x + (v != 0 ? 0 : k);
      cy = y + (v != 0 ? k : 0);
      if (cx < 0 || cx >= COLS || cy < 0 || cy >= ROWS) return 0;
      if (m_occ[cy][cx] != 0) return 0;
    end
    return 1;
  endfunction

  always @(posedge frame_clk) begin : model
    bit ev, act, full;
    int dst;
    if (Reset) begin
      foreach (m_occ[r, c]) begin m_occ[r][c] = 0; m_col[r][c] = 0; end
      m_x = SPAWN_X; m_y = 0; m_v = 0; m_pc = 1; m_grav = 0; m_prev = 0;
      m_mode = MF; m_lines = 0; m_valid = 1;
    end else if (m_valid) begin
      ev = (keycode != 0) && (int'(keycode) != m_prev);
      m_prev = int'(keycode);
      case (m_mode)
        MF: begin
          act = ev && (keycode inside {K_LEFT, K_RIGHT, K_ROT, K_DOWN, K_DROP});
          if (act) begin
            case (keycode)
              K_LEFT:  if (m_fits(m_x - 1, m_y, m_v)) m_x--;
              K_RIGHT: if (m_fits(m_x + 1, m_y, m_v)) m_x++;
              K_ROT:   if (m_fits(m_x, m_y, 1 - m_v)) m_v = 1 - m_v;
              K_DOWN:  if (m_fits(m_x, m_y + 1, m_v)) m_y++; else m_mode = ML;
              K_DROP:  m_mode = MH;
              default: ;
            endcase
            if (keycode == K_DOWN) m_grav = 0;
            else if (m_grav != DROP_PERIOD - 1) m_grav++;
          end else if (m_grav == DROP_PERIOD - 1) begin
            m_grav = 0;
            if (m_fits(m_x, m_y + 1, m_v)) m_y++; else m_mode = ML;
          end else begin
            m_grav++;
          end
        end
        MH: if (m_fits(m_x, m_y + 1, m_v)) m_y++; else m_mode = ML;
        ML: begin
          for (int k = 0; k < PIECE_LEN; k++) begin
            m_occ[m_y + (m_v != 0 ? k : 0)][m_x + (m_v != 0 ? 0 : k)] = 1;
            m_col[m_y + (m_v != 0 ? k : 0)][m_x + (m_v != 0 ? 0 : k)] = m_pc;
          end
          // Final field: surviving rows keep their order, packed at the bottom.
          foreach (p_occ[r, c]) begin p_occ[r][c] = 0; p_col[r][c] = 0; end
          dst = ROWS - 1; m_k = 0;
          for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1;
            for (int c = 0; c < COLS; c++) if (m_occ[r][c] == 0) full = 0;
            if (full) m_k++;
            else begin
              for (int c = 0; c < COLS; c++) begin
                p_occ[dst][c] = m_occ[r][c]; p_col[dst][c] = m_col[r][c];
              end
              dst--;
            end
          end
          m_left = ROWS + m_k;
          m_mode = MC;
        end
        MC: begin
          m_left--;
          if (m_left == 0) begin
            m_occ = p_occ; m_col = p_col;
            m_lines = (m_lines + m_k > 65535) ? 65535 : m_lines + m_k;
            m_mode = MS;
          end
        end
        MS: begin
          m_x = SPAWN_X; m_y = 0; m_v = 0; m_grav = 0;
          m_pc = (m_pc == 3) ? 1 : m_pc + 1;
          m_mode = m_fits(SPAWN_X, 0, 0) ? MF : MO;
        end
        default: ;
      endcase
    end
  end

  always @(negedge frame_clk) begin : compare
    logic [ROWS*COLS-1:0]   eo;
    logic [2*ROWS*COLS-1:0] ec;
    if (m_valid) begin
      check("piece_x", piece_x, m_x);
      check("piece_y", piece_y, m_y);
      check("piece_vert", piece_vert, m_v);
      check("piece_color", piece_color, m_pc);
      check("busy", busy, m_mode inside {MH, ML, MC, MS});
      check("game_over", game_over, m_mode == MO);
      if (m_mode != MC) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            eo[r*COLS + c] = (m_occ[r][c] != 0);
            ec[(r*COLS + c)*2 +: 2] = 2'(m_col[r][c]);
          end
        check("grid_occ", grid_occ, eo);
        check("grid_color", grid_color, ec);
        check("lines_cleared", lines_cleared, m_lines);
      end
    end
  end

  task automatic tick(input logic [7:0] k);
    keycode = k;
    @(negedge frame_clk);
  endtask

  task automatic press(input logic [7:0] k);
    tick(k);
    tick(8'h00);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(8'h00);
    tick(8'h00);
    Reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin tick(8'h00); n++; end
    check(tag, busy, 1'b0);
  endtask

  // From a fresh spawn: optionally stand up, walk to col, hard drop.
  task automatic place(input bit vert, input int col);
    if (vert) press(K_ROT);
    for (int i = SPAWN_X; i > col; i--) press(K_LEFT);
    for (int i = SPAWN_X; i < col; i++) press(K_RIGHT);
    press(K_DROP);
    wait_idle("place_idle");
  endtask

  initial begin
    Reset = 1'b1;
    keycode = 8'h00;
    do_reset();
    check("rst_x", piece_x, 3);
    check("rst_busy", busy, 0);

    // Gravity: first step on frame 30
    repeat (29) tick(8'h00);
    check("grav_y_29", piece_y, 0);
    tick(8'h00);
    check("grav_y_30", piece_y, 1);
    check("grav_x", piece_x, 3);

    // Key on the gravity frame wins; gravity follows next frame
    repeat (29) tick(8'h00);
    tick(K_RIGHT);
    check("keywin_x", piece_x, 4);
    check("keywin_y", piece_y, 1);
    tick(8'h00);
    check("defer_y", piece_y, 2);
    press(K_LEFT);

    // Held key acts once, repeated presses stop at the wall
    repeat (10) tick(K_LEFT);
    check("hold_left", piece_x, 2);
    repeat (5) begin tick(8'h00); tick(K_LEFT); end
    check("left_wall", piece_x, 0);
    repeat (9) begin tick(8'h00); tick(K_RIGHT); end
    check("right_wall", piece_x, 6);
    tick(8'h00);

    // Rotation with and without room
    press(K_ROT);
    check("rot_vert", piece_vert, 1);
    press(K_RIGHT);
    check("vert_x7", piece_x, 7);
    press(K_ROT);
    check("rot_reject", piece_vert, 1);
    press(K_LEFT);
    press(K_ROT);
    check("rot_back", piece_vert, 0);
    check("rot_back_x", piece_x, 6);
    press(K_DOWN);

    // Hard drop on an empty field
    do_reset();
    tick(K_DROP);
    check("hard_busy", busy, 1);
    repeat (19) tick(8'h00);
    check("hard_y19", piece_y, 19);
    tick(8'h00);
    tick(8'h00);
    check("lock_bits", grid_occ[196:193], 4'hF);
    check("lock_col_a", grid_color[193*2 +: 2], 1);
    check("lock_col_b", grid_color[196*2 +: 2], 1);
    wait_idle("hard_idle");
    check("spawn_color", piece_color, 2);
    check("spawn_y", piece_y, 0);

    // Single line clear
    do_reset();
    place(0, 0);
    place(1, 4);
    place(1, 5);
    place(0, 6);
    check("clr1_lines", lines_cleared, 1);
    check("clr1_row19", grid_occ[199:190], 10'h030);

    // Double line clear with a vertical finisher
    place(0, 0);
    place(0, 0);
    place(1, 6);
    place(1, 7);
    place(1, 8);
    check("pre2_lines", lines_cleared, 1);
    place(1, 9);
    check("clr2_lines", lines_cleared, 3);
    check("clr2_row19", grid_occ[199:190], 10'h3F0);
    check("clr2_row18", grid_occ[189:180], 10'h3C0);
    check("clr2_row17", grid_occ[179:170], 10'h000);

    // Stack column 3 to the top
    do_reset();
    repeat (4) place(1, 3);
    check("stack_not_over", game_over, 0);
    place(1, 3);
    check("over", game_over, 1);
    press(K_LEFT);
    press(K_RIGHT);
    press(K_ROT);
    press(K_DROP);
    check("over_x", piece_x, 3);
    check("over_vert", piece_vert, 0);
    check("over_busy", busy, 0);
    check("over_hold", game_over, 1);

    do_reset();
    check("rst2_grid", grid_occ, '0);
    check("rst2_over", game_over, 0);
    check("rst2_color", piece_color, 1);
    check("rst2_lines", lines_cleared, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
